muldiv_sequencer: RTL and testbench

MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

---
 rtl/muldiv_pkg.sv | 28 ++
 rtl/muldiv_step.sv | 32 +++
 rtl/muldiv_sequencer.sv | 138 +++++++++++++
 tb/tb_muldiv_sequencer.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the sequential signed multiply/divide unit.
// Optional feature macro: DIV_BY_ZERO_EXC_EN (adds the ERR state).
package muldiv_pkg;

  localparam int unsigned DATA_W         = 32;
  localparam int unsigned ACC_W          = 64;
  localparam int unsigned CNT_W          = 5;
  localparam int unsigned STEP_COUNT_MAX = 31;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RUN  = 3'd1,
    ST_FIX  = 3'd2,
`ifdef DIV_BY_ZERO_EXC_EN
    ST_ERR  = 3'd4,
`endif
    ST_DONE = 3'd3
  } state_t;

  // Two's-complement magnitude; 0x80000000 maps to itself, read as unsigned.
  function automatic logic [DATA_W-1:0] abs_val(input logic [DATA_W-1:0] x);
    return x[DATA_W-1] ? DATA_W'(~x + DATA_W'(1)) : x;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration over the 64-bit accumulator:
// multiply = conditional add of the operand into the upper word, then shift right;
// divide   = restoring shift-left and trial subtract of the divisor.
module muldiv_step
  import muldiv_pkg::*;
(
  input  logic              op,
  input  logic [ACC_W-1:0]  acc,
  input  logic [DATA_W-1:0] operand,
  output logic [ACC_W-1:0]  acc_next_c
);

  logic [DATA_W:0]   sum;
  logic [DATA_W:0]   shifted;
  logic [DATA_W+1:0] diff;

  // Arithmetic for both operations; op selects which result is kept.
  always_comb begin
    sum        = {1'b0, acc[ACC_W-1:DATA_W]} + (acc[0] ? {1'b0, operand} : '0);
    shifted    = acc[ACC_W-1:DATA_W-1];
    diff       = {1'b0, shifted} - {2'b00, operand};
    acc_next_c = acc;
    if (op == OP_MULT) begin
      acc_next_c = {sum, acc[DATA_W-1:1]};
    end else if (!diff[DATA_W+1]) begin
      acc_next_c = {diff[DATA_W-1:0], acc[DATA_W-2:0], 1'b1};
    end else begin
      acc_next_c = {shifted[DATA_W-1:0], acc[DATA_W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Sequential 32x32 signed multiply / 32/32 signed divide, 34 cycles per op.
// Operates on magnitudes, then applies sign correction in a single FIX cycle.
// Optional feature macro: DIV_BY_ZERO_EXC_EN (early divide-by-zero exit via ERR).
module muldiv_sequencer
  import muldiv_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic              divZero
);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              op_q;
  logic              sign_a;
  logic              sign_b;
  logic [DATA_W-1:0] operand_q;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  acc_step_c;
  logic [ACC_W-1:0]  fixed_c;
  logic [DATA_W-1:0] mag_a_c;
  logic [DATA_W-1:0] mag_b_c;

`ifdef DIV_BY_ZERO_EXC_EN
  logic div_zero_q;
  assign divZero = div_zero_q;
`else
  assign divZero = 1'b0;
`endif

  assign mag_a_c = abs_val(a);
  assign mag_b_c = abs_val(b);

  muldiv_step u_step (
    .op         (op_q),
    .acc        (acc),
    .operand    (operand_q),
    .acc_next_c (acc_step_c)
  );

  // Sign correction of the magnitude result held in acc.
  always_comb begin
    fixed_c = acc;
    if (op_q == OP_MULT) begin
      if (sign_a ^ sign_b) fixed_c = ACC_W'(~acc + ACC_W'(1));
    end else begin
      if (sign_a)          fixed_c[ACC_W-1:DATA_W] = DATA_W'(~acc[ACC_W-1:DATA_W] + DATA_W'(1));
      if (sign_a ^ sign_b) fixed_c[DATA_W-1:0]     = DATA_W'(~acc[DATA_W-1:0] + DATA_W'(1));
    end
  end

  // Control FSM, step counter, operand capture and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      op_q      <= OP_MULT;
      sign_a    <= 1'b0;
      sign_b    <= 1'b0;
      operand_q <= '0;
      acc       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      hi        <= '0;
      lo        <= '0;
`ifdef DIV_BY_ZERO_EXC_EN
      div_zero_q <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
`ifdef DIV_BY_ZERO_EXC_EN
      div_zero_q <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (start) begin
            busy <= 1'b1;
`ifdef DIV_BY_ZERO_EXC_EN
            if (op == OP_DIV && b == '0) begin
              state <= ST_ERR;
            end else begin
              state <= ST_RUN;
            end
`else
            state <= ST_RUN;
`endif
            op_q      <= op;
            sign_a    <= a[DATA_W-1];
            sign_b    <= b[DATA_W-1];
            cnt       <= CNT_W'(STEP_COUNT_MAX);
            operand_q <= (op == OP_MULT) ? mag_a_c : mag_b_c;
            acc       <= {{DATA_W{1'b0}}, (op == OP_MULT) ? mag_b_c : mag_a_c};
          end
        end
        ST_RUN: begin
          acc <= acc_step_c;
          if (cnt == '0) begin
            state <= ST_FIX;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_FIX: begin
          acc   <= fixed_c;
          state <= ST_DONE;
        end
        ST_DONE: begin
          hi    <= acc[ACC_W-1:DATA_W];
          lo    <= acc[DATA_W-1:0];
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
`ifdef DIV_BY_ZERO_EXC_EN
        ST_ERR: begin
          done       <= 1'b1;
          div_zero_q <= 1'b1;
          busy       <= 1'b0;
          state      <= ST_IDLE;
        end
`endif
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed self-checking bench for muldiv_sequencer (hand-computed vectors).
module tb_muldiv_sequencer;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic        op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        divZero;

  int total;
  int bad;

  muldiv_sequencer dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .hi      (hi),
    .lo      (lo),
    .divZero (divZero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Issue one operation and watch 60 cycles; restart_at > 0 re-pulses start mid-run.
  task automatic run_op(input logic o, input logic [31:0] x, input logic [31:0] y,
                        input int restart_at,
                        output int lat, output int bcnt, output int dcnt, output logic dz);
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; a = 32'h1234_5678; b = 32'h0000_0003; op = ~o;
    lat = 0; bcnt = 0; dcnt = 0; dz = 1'b0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (busy) bcnt++;
      if (done) begin
        dcnt++;
        if (lat == 0) begin
          lat = i;
          dz  = divZero;
        end
      end
      start = (i == restart_at);
    end
    start = 1'b0;
  endtask

  int   lat, bcnt, dcnt;
  logic dz;

  initial begin
    total = 0; bad = 0;
    reset_n = 1'b0; start = 1'b0; op = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    check("rst_dz", 64'(divZero), 64'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // 6 * -7 = -42
    run_op(1'b0, 32'd6, 32'hFFFF_FFF9, 0, lat, bcnt, dcnt, dz);
    check("mul_lat", 64'(lat), 64'd35);
    check("mul_busy", 64'(bcnt), 64'd34);
    check("mul_ndone", 64'(dcnt), 64'd1);
    check("mul_hi", 64'(hi), 64'hFFFF_FFFF);
    check("mul_lo", 64'(lo), 64'hFFFF_FFD6);

    // -2^31 * -2^31 = 2^62
    run_op(1'b0, 32'h8000_0000, 32'h8000_0000, 0, lat, bcnt, dcnt, dz);
    check("mulmin_hi", 64'(hi), 64'h4000_0000);
    check("mulmin_lo", 64'(lo), 64'h0);

    // -1 * -1 = 1
    run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, lat, bcnt, dcnt, dz);
    check("mulm1_hi", 64'(hi), 64'h0);
    check("mulm1_lo", 64'(lo), 64'h1);

    // 100 / -7 = -14 rem 2
    run_op(1'b1, 32'd100, 32'hFFFF_FFF9, 0, lat, bcnt, dcnt, dz);
    check("div100_lo", 64'(lo), 64'hFFFF_FFF2);
    check("div100_hi", 64'(hi), 64'h2);

    // -2^31 / -1 = -2^31 rem 0, no flag
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, lat, bcnt, dcnt, dz);
    check("divmin_lo", 64'(lo), 64'h8000_0000);
    check("divmin_hi", 64'(hi), 64'h0);
    check("divmin_dz", 64'(dz), 64'd0);

    // -7 / 2 = -3 rem -1
    run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 0, lat, bcnt, dcnt, dz);
    check("div7_lo", 64'(lo), 64'hFFFF_FFFD);
    check("div7_hi", 64'(hi), 64'hFFFF_FFFF);
    check("div7_busy", 64'(bcnt), 64'd34);
    check("div7_lat", 64'(lat), 64'd35);

    // 7 / 0
    run_op(1'b1, 32'd7, 32'd0, 0, lat, bcnt, dcnt, dz);
`ifdef DIV_BY_ZERO_EXC_EN
    check("div0_lat", 64'(lat), 64'd2);
    check("div0_dz", 64'(dz), 64'd1);
    check("div0_ndone", 64'(dcnt), 64'd1);
    check("div0_lo", 64'(lo), 64'hFFFF_FFFD);
    check("div0_hi", 64'(hi), 64'hFFFF_FFFF);
`else
    check("div0_lat", 64'(lat), 64'd35);
    check("div0_dz", 64'(dz), 64'd0);
    check("div0_lo", 64'(lo), 64'hFFFF_FFFF);
    check("div0_hi", 64'(hi), 64'h7);
`endif

    // start re-pulsed during RUN must be ignored: 6 * -7 again
    run_op(1'b0, 32'd6, 32'hFFFF_FFF9, 10, lat, bcnt, dcnt, dz);
    check("rep_lat", 64'(lat), 64'd35);
    check("rep_ndone", 64'(dcnt), 64'd1);
    check("rep_hi", 64'(hi), 64'hFFFF_FFFF);
    check("rep_lo", 64'(lo), 64'hFFFF_FFD6);

    // Reset in the middle of RUN discards the operation
    @(negedge clk);
    op = 1'b1; a = 32'd100; b = 32'd3; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (15) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_hi", 64'(hi), 64'd0);
    check("mid_rst_lo", 64'(lo), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    dcnt = 0; bcnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) dcnt++;
      if (busy) bcnt++;
    end
    check("post_rst_ndone", 64'(dcnt), 64'd0);
    check("post_rst_busy", 64'(bcnt), 64'd0);
    check("post_rst_hi", 64'(hi), 64'd0);
    check("post_rst_lo", 64'(lo), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
